rf_write_arbiter: RTL and testbench



---
 rtl/rf_write_arbiter.sv | 152 +++++++++++++++
 tb/tb_rf_write_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Write-port arbiter for the register file: shares one write port between writeback (A) and a long-latency unit (B).
// Optional post-reset zero-fill of r1..r31 is built when RF_CLEAR_ON_RESET_EN is defined.
module rf_write_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_a_valid,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_data,
  output logic              o_a_ready,
  input  logic              i_b_valid,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [DATA_W-1:0] i_b_data,
  output logic              o_b_ready,
  output logic              o_rf_we,
  output logic [ADDR_W-1:0] o_rf_waddr,
  output logic [DATA_W-1:0] o_rf_wdata,
  output logic              o_busy
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic              in_run;
  logic              clr_active;
  logic              force_b;
  logic              a_fire;
  logic              b_fire;
  logic [3:0]        starve_cnt;
  logic              nxt_load;
  logic              nxt_we;
  logic [ADDR_W-1:0] nxt_addr;
  logic [DATA_W-1:0] nxt_data;

`ifdef RF_CLEAR_ON_RESET_EN
  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t     state;
  logic [4:0] clr_addr;

  // Clear sequencer: walks r1..r31 once, then hands the port to the writers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= CLEAR;
      clr_addr <= 5'd1;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_addr == 5'd31) begin
            state <= RUN;
          end else begin
            clr_addr <= clr_addr + 5'd1;
          end
        end
        RUN:     state <= RUN;
        default: state <= CLEAR;
      endcase
    end
  end

  assign clr_active = (state == CLEAR);
  assign in_run     = i_rst_n && (state == RUN);
  assign o_busy     = (state == CLEAR);
`else
  assign clr_active = 1'b0;
  assign in_run     = i_rst_n;
  assign o_busy     = 1'b0;
`endif

  // Handshake: A has priority unless B has been refused STARVE_LIMIT times in a row
  always_comb begin
    force_b   = 1'b0;
    o_a_ready = 1'b0;
    o_b_ready = 1'b0;
    if (in_run) begin
      force_b   = i_b_valid && (starve_cnt == LIMIT);
      o_a_ready = !force_b;
      o_b_ready = force_b || !i_a_valid;
    end else begin
      force_b   = 1'b0;
      o_a_ready = 1'b0;
      o_b_ready = 1'b0;
    end
    a_fire = i_a_valid && o_a_ready;
    b_fire = i_b_valid && o_b_ready && !a_fire;
  end

  // Starvation counter: counts consecutive refused B cycles, saturating at the limit
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      starve_cnt <= 4'd0;
    end else if (!i_b_valid || b_fire) begin
      starve_cnt <= 4'd0;
    end else if (starve_cnt == LIMIT) begin
      starve_cnt <= LIMIT;
    end else begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Next write: clear traffic, then A, then B; r0 targets are swallowed
  always_comb begin
    nxt_load = 1'b0;
    nxt_we   = 1'b0;
    nxt_addr = i_a_addr;
    nxt_data = i_a_data;
    if (clr_active) begin
      nxt_load = 1'b1;
      nxt_we   = 1'b1;
`ifdef RF_CLEAR_ON_RESET_EN
      nxt_addr = ADDR_W'(clr_addr);
`else
      nxt_addr = {ADDR_W{1'b0}};
`endif
      nxt_data = {DATA_W{1'b0}};
    end else if (a_fire) begin
      nxt_load = 1'b1;
      nxt_we   = (i_a_addr != {ADDR_W{1'b0}});
      nxt_addr = i_a_addr;
      nxt_data = i_a_data;
    end else if (b_fire) begin
      nxt_load = 1'b1;
      nxt_we   = (i_b_addr != {ADDR_W{1'b0}});
      nxt_addr = i_b_addr;
      nxt_data = i_b_data;
    end else begin
      nxt_load = 1'b0;
      nxt_we   = 1'b0;
    end
  end

  // Output register: one-cycle pipeline into the register file write port
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rf_we    <= 1'b0;
      o_rf_waddr <= {ADDR_W{1'b0}};
      o_rf_wdata <= {DATA_W{1'b0}};
    end else begin
      o_rf_we <= nxt_we;
      if (nxt_load) begin
        o_rf_waddr <= nxt_addr;
        o_rf_wdata <= nxt_data;
      end else begin
        o_rf_waddr <= o_rf_waddr;
        o_rf_wdata <= o_rf_wdata;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: priority, starvation, r0 filtering, reset behaviour.
// Follows RF_CLEAR_ON_RESET_EN the same way the design does.
module tb_rf_write_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, rf_we, busy;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  int          vectors = 0;
  int          miscompares = 0;

  rf_write_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_valid(a_valid), .i_a_addr(a_addr), .i_a_data(a_data), .o_a_ready(a_ready),
    .i_b_valid(b_valid), .i_b_addr(b_addr), .i_b_data(b_data), .o_b_ready(b_ready),
    .o_rf_we(rf_we), .o_rf_waddr(rf_waddr), .o_rf_wdata(rf_wdata), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic [4:0] ad, input logic [31:0] d);
    a_valid = v; a_addr = ad; a_data = d;
  endtask

  task automatic set_b(input logic v, input logic [4:0] ad, input logic [31:0] d);
    b_valid = v; b_addr = ad; b_data = d;
  endtask

  // Walks the 31-cycle zero-fill (no-op without the clear feature)
  task automatic run_clear();
`ifdef RF_CLEAR_ON_RESET_EN
    set_a(1'b1, 5'd4, 32'h0000_0044);
    for (int c = 0; c < 31; c++) begin
      #1;
      chk("clr_busy", {63'd0, busy}, 64'd1);
      chk("clr_a_ready", {63'd0, a_ready}, 64'd0);
      chk("clr_b_ready", {63'd0, b_ready}, 64'd0);
      tick();
      chk("clr_we", {63'd0, rf_we}, 64'd1);
      chk("clr_addr", {59'd0, rf_waddr}, 64'(c + 1));
      chk("clr_data", {32'd0, rf_wdata}, 64'd0);
    end
    set_a(1'b0, 5'd0, 32'd0);
    #1;
    chk("clr_done_busy", {63'd0, busy}, 64'd0);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    set_a(1'b0, 5'd0, 32'd0);
    set_b(1'b0, 5'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", {63'd0, rf_we}, 64'd0);
    chk("rst_waddr", {59'd0, rf_waddr}, 64'd0);
    chk("rst_wdata", {32'd0, rf_wdata}, 64'd0);
    chk("rst_a_ready", {63'd0, a_ready}, 64'd0);
    chk("rst_b_ready", {63'd0, b_ready}, 64'd0);
`ifdef RF_CLEAR_ON_RESET_EN
    chk("rst_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b1;
    // Reset mid-clear at cycle 10: output write dropped at once, then restart from r1
    repeat (10) tick();
    chk("mid_clr_addr", {59'd0, rf_waddr}, 64'd10);
    rst_n = 1'b0;
    #1;
    chk("mid_clr_we", {63'd0, rf_we}, 64'd0);
    chk("mid_clr_busy", {63'd0, busy}, 64'd1);
    tick();
    rst_n = 1'b1;
    run_clear();
`else
    chk("rst_busy", {63'd0, busy}, 64'd0);
    rst_n = 1'b1;
`endif

    // First A write right after the port becomes available
    set_a(1'b1, 5'd3, 32'h0000_00AA);
    #1;
    chk("first_a_ready", {63'd0, a_ready}, 64'd1);
    chk("first_busy", {63'd0, busy}, 64'd0);
    tick();
    chk("first_we", {63'd0, rf_we}, 64'd1);
    chk("first_addr", {59'd0, rf_waddr}, 64'd3);
    chk("first_data", {32'd0, rf_wdata}, 64'h0000_00AA);

    // Priority: A wins a tie, B follows once A drops
    set_a(1'b1, 5'd5, 32'h1111_1111);
    set_b(1'b1, 5'd6, 32'h2222_2222);
    #1;
    chk("prio_a_ready", {63'd0, a_ready}, 64'd1);
    chk("prio_b_ready", {63'd0, b_ready}, 64'd0);
    tick();
    chk("prio_a_addr", {59'd0, rf_waddr}, 64'd5);
    chk("prio_a_data", {32'd0, rf_wdata}, 64'h1111_1111);
    set_a(1'b0, 5'd0, 32'd0);
    #1;
    chk("prio_b_ready2", {63'd0, b_ready}, 64'd1);
    tick();
    chk("prio_b_we", {63'd0, rf_we}, 64'd1);
    chk("prio_b_addr", {59'd0, rf_waddr}, 64'd6);
    chk("prio_b_data", {32'd0, rf_wdata}, 64'h2222_2222);
    set_b(1'b0, 5'd0, 32'd0);
    tick();
    chk("idle_we", {63'd0, rf_we}, 64'd0);
    chk("idle_addr_hold", {59'd0, rf_waddr}, 64'd6);

    // Starvation: A every cycle, B forced through on its 5th valid cycle
    set_b(1'b1, 5'd9, 32'h3333_3333);
    for (int i = 0; i < 5; i++) begin
      set_a(1'b1, 5'(10 + i), 32'(i + 16));
      #1;
      chk("starve_a_ready", {63'd0, a_ready}, (i == 4) ? 64'd0 : 64'd1);
      chk("starve_b_ready", {63'd0, b_ready}, (i == 4) ? 64'd1 : 64'd0);
      tick();
      chk("starve_we", {63'd0, rf_we}, 64'd1);
      chk("starve_addr", {59'd0, rf_waddr}, (i == 4) ? 64'd9 : 64'(10 + i));
      chk("starve_data", {32'd0, rf_wdata}, (i == 4) ? 64'h3333_3333 : 64'(i + 16));
    end
    // Counter restarted: a fresh B request must lose to A again
    set_a(1'b1, 5'd20, 32'h0000_0020);
    set_b(1'b1, 5'd7, 32'h4444_4444);
    #1;
    chk("restart_a_ready", {63'd0, a_ready}, 64'd1);
    chk("restart_b_ready", {63'd0, b_ready}, 64'd0);
    tick();
    chk("restart_addr", {59'd0, rf_waddr}, 64'd20);
    set_a(1'b0, 5'd0, 32'd0);
    tick();
    chk("restart_b_addr", {59'd0, rf_waddr}, 64'd7);
    chk("restart_b_data", {32'd0, rf_wdata}, 64'h4444_4444);
    set_b(1'b0, 5'd0, 32'd0);

    // r0 filter: accepted but never written
    set_a(1'b1, 5'd0, 32'hDEAD_BEEF);
    #1;
    chk("r0_a_ready", {63'd0, a_ready}, 64'd1);
    tick();
    chk("r0_we", {63'd0, rf_we}, 64'd0);

    // Reset mid-run drops the pending write immediately
    set_a(1'b1, 5'd12, 32'h0000_0055);
    tick();
    chk("run_we", {63'd0, rf_we}, 64'd1);
    set_a(1'b0, 5'd0, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("run_rst_we", {63'd0, rf_we}, 64'd0);
    chk("run_rst_addr", {59'd0, rf_waddr}, 64'd0);
    chk("run_rst_a_ready", {63'd0, a_ready}, 64'd0);
    tick();
    rst_n = 1'b1;
    run_clear();
    set_a(1'b1, 5'd13, 32'h0000_0077);
    #1;
    chk("post_rst_a_ready", {63'd0, a_ready}, 64'd1);
    tick();
    chk("post_rst_addr", {59'd0, rf_waddr}, 64'd13);
    chk("post_rst_data", {32'd0, rf_wdata}, 64'h0000_0077);
    set_a(1'b0, 5'd0, 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
